// File: rtl/mem_access_ctrl.sv
//==============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage access controller for a 16-bit asynchronous SRAM.
//            Each 32-bit load/store becomes two 16-bit SRAM accesses (low
//            half first, then high half). Each half lasts WAIT_CYCLES clocks.
//            The pipeline is stalled through `ready` while an access is in
//            flight.
// Ports    : clk, rst (async, active-low)
//            rdEn/wrEn      - load/store request (level, held until ready)
//            address        - byte address; writeData - store data
//            readData       - assembled 32-bit load result
//            ready          - 1 = pipeline may advance
//            sramAddr       - SRAM halfword address
//            sramDqOut/In   - SRAM data out / in; sramDqOe - drive enable
//            sramWeN        - SRAM write enable, active-low
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,          // 1..15
  parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdEn,
  input  logic        wrEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] sramAddr,
  output logic [15:0] sramDqOut,
  input  logic [15:0] sramDqIn,
  output logic        sramDqOe,
  output logic        sramWeN
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_lo     = 2'd1;
  localparam logic [1:0] c_hi     = 2'd2;
  localparam logic [1:0] c_done   = 2'd3;
  localparam logic [3:0] c_last   = 4'(WAIT_CYCLES - 1);
  localparam bit         c_single = (WAIT_CYCLES == 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [3:0]  r_cnt;
  logic [16:0] r_idx;
  logic [15:0] r_wdata_hi;   // low half goes straight to sramDqOut on start
  logic        r_wr;
  logic [31:0] w_offset;
  logic [16:0] w_idx;
  logic        w_req;
  logic        w_last;
  logic        w_unused;

  // Word index is taken from the full 32-bit offset so a misaligned base
  // still borrows correctly into bit 2.
  assign w_offset = address - ADDR_BASE;
  assign w_idx    = w_offset[18:2];
  assign w_unused = ^{w_offset[31:19], w_offset[1:0]};
  assign w_req    = rdEn | wrEn;
  assign w_last   = (r_cnt == c_last);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (w_req)  w_next = c_lo;
      c_lo:    if (w_last) w_next = c_hi;
      c_hi:    if (w_last) w_next = c_done;
      c_done:  w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  // Outputs decoded from state. Keeping the SRAM strobes combinational means
  // an asynchronous reset releases the bus in the same instant.
  always_comb begin
    ready    = 1'b0;
    sramDqOe = 1'b0;
    sramWeN  = 1'b1;
    case (r_state)
      c_idle: ready = ~w_req;
      c_lo, c_hi: begin
        sramDqOe = r_wr;
        // WE# rises one cycle before the address changes so data/address
        // hold is met; with a single wait cycle there is no room for that.
        sramWeN  = ~(r_wr & (c_single | ~w_last));
      end
      c_done: ready = 1'b1;
      default: ;
    endcase
  end

  // Datapath: request latch, wait counter, SRAM address/data, load assembly.
  // sramAddr/sramDqOut are loaded on the edge that enters each half so they
  // are stable for the whole half and hold afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 4'd0;
      r_idx      <= 17'd0;
      r_wdata_hi <= 16'd0;
      r_wr       <= 1'b0;
      readData   <= 32'd0;
      sramAddr   <= 18'd0;
      sramDqOut  <= 16'd0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_req) begin
            r_idx      <= w_idx;
            r_wdata_hi <= writeData[31:16];
            r_wr       <= wrEn;           // simultaneous rd+wr is a write
            r_cnt      <= 4'd0;
            sramAddr   <= {w_idx, 1'b0};
            if (wrEn) begin
              sramDqOut <= writeData[15:0];
            end
          end
        end
        c_lo: begin
          if (w_last) begin
            r_cnt    <= 4'd0;
            sramAddr <= {r_idx, 1'b1};
            if (r_wr) begin
              sramDqOut <= r_wdata_hi;
            end else begin
              readData[15:0] <= sramDqIn;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        c_hi: begin
          if (w_last) begin
            r_cnt <= 4'd0;
            if (!r_wr) begin
              readData[31:16] <= sramDqIn;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
//==============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl. Two instances are used,
//            one with WAIT_CYCLES=2 and one with WAIT_CYCLES=1, each attached
//            to a small behavioural SRAM. Per access, the expected per-cycle
//            bus trace is pushed to a scoreboard queue and popped/compared as
//            the DUT steps through the access.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance with two wait cycles per half
  logic        rd2, wr2, ready2, oe2, wen2;
  logic [31:0] addr2, wd2, rdata2;
  logic [17:0] sa2;
  logic [15:0] dqo2, dqi2;

  // Instance with one wait cycle per half
  logic        rd1, wr1, ready1, oe1, wen1;
  logic [31:0] addr1, wd1, rdata1;
  logic [17:0] sa1;
  logic [15:0] dqo1, dqi1;

  mem_access_ctrl #(.WAIT_CYCLES(2), .ADDR_BASE(32'd1024)) dut2 (
    .clk(clk), .rst(rst), .rdEn(rd2), .wrEn(wr2), .address(addr2),
    .writeData(wd2), .readData(rdata2), .ready(ready2), .sramAddr(sa2),
    .sramDqOut(dqo2), .sramDqIn(dqi2), .sramDqOe(oe2), .sramWeN(wen2)
  );

  mem_access_ctrl #(.WAIT_CYCLES(1), .ADDR_BASE(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .rdEn(rd1), .wrEn(wr1), .address(addr1),
    .writeData(wd1), .readData(rdata1), .ready(ready1), .sramAddr(sa1),
    .sramDqOut(dqo1), .sramDqIn(dqi1), .sramDqOe(oe1), .sramWeN(wen1)
  );

  // Behavioural SRAMs: asynchronous read, write while WE# is low at a clock.
  logic [15:0] mem2 [0:1023];
  logic [15:0] mem1 [0:1023];
  logic        tb_unused;
  assign dqi2 = mem2[sa2[9:0]];
  assign dqi1 = mem1[sa1[9:0]];
  assign tb_unused = ^{sa2[17:10], sa1[17:10]};
  always @(posedge clk) if (!wen2) mem2[sa2[9:0]] <= dqo2;
  always @(posedge clk) if (!wen1) mem1[sa1[9:0]] <= dqo1;

  typedef struct {
    int          cyc;
    bit          rdy;
    bit          wen;
    bit          oe;
    bit          chk_a;
    logic [17:0] a;
    bit          chk_d;
    logic [15:0] d;
    bit          chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one access (caller is just after a rising edge with the DUT idle),
  // build the expected trace for cycles 0..2W+1, then compare cycle by cycle.
  // Returns at the falling edge of the DONE cycle.
  task automatic access(input bit w1, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input int w, input logic [31:0] exp_rd);
    logic [31:0] idx;
    logic [17:0] lo, hi;
    exp_t        e;
    bit          hiph;
    int          p;
    string       nm;
    logic        o_rdy, o_wen, o_oe;
    logic [17:0] o_a;
    logic [15:0] o_d;
    logic [31:0] o_rd;

    nm  = w1 ? "W1" : "W2";
    idx = (a - 32'd1024) >> 2;
    lo  = 18'(idx * 2);
    hi  = lo + 18'd1;

    if (w1) begin
      rd1 = rd; wr1 = wr; addr1 = a; wd1 = d;
    end else begin
      rd2 = rd; wr2 = wr; addr2 = a; wd2 = d;
    end

    for (int c = 0; c <= 2*w + 1; c++) begin
      e.cyc = c;  e.rdy = (c == 2*w + 1);
      e.wen = 1'b1; e.oe = 1'b0;
      e.chk_a = 1'b0; e.a = '0;
      e.chk_d = 1'b0; e.d = '0;
      e.chk_rd = 1'b0; e.rd = '0;
      if (c >= 1 && c <= 2*w) begin
        hiph    = (c > w);
        p       = hiph ? c - w : c;
        e.chk_a = 1'b1;
        e.a     = hiph ? hi : lo;
        if (wr) begin
          e.oe    = 1'b1;
          e.wen   = (w > 1) && (p == w);
          e.chk_d = 1'b1;
          e.d     = hiph ? d[31:16] : d[15:0];
        end
      end
      if (c == 2*w + 1) begin
        e.chk_a  = 1'b1;  e.a  = hi;
        e.chk_rd = 1'b1;  e.rd = exp_rd;
      end
      sb.push_back(e);
    end

    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      if (w1) begin
        o_rdy = ready1; o_wen = wen1; o_oe = oe1; o_a = sa1; o_d = dqo1; o_rd = rdata1;
      end else begin
        o_rdy = ready2; o_wen = wen2; o_oe = oe2; o_a = sa2; o_d = dqo2; o_rd = rdata2;
      end
      chk($sformatf("%s @%0h c%0d ready", nm, a, e.cyc), 32'(o_rdy), 32'(e.rdy));
      chk($sformatf("%s @%0h c%0d weN", nm, a, e.cyc), 32'(o_wen), 32'(e.wen));
      chk($sformatf("%s @%0h c%0d oe", nm, a, e.cyc), 32'(o_oe), 32'(e.oe));
      if (e.chk_a)  chk($sformatf("%s @%0h c%0d sramAddr", nm, a, e.cyc), 32'(o_a), 32'(e.a));
      if (e.chk_d)  chk($sformatf("%s @%0h c%0d dqOut", nm, a, e.cyc), 32'(o_d), 32'(e.d));
      if (e.chk_rd) chk($sformatf("%s @%0h c%0d readData", nm, a, e.cyc), o_rd, e.rd);
      if (sb.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
    rd2 = 1'b0; wr2 = 1'b1; addr2 = 32'd1024; wd2 = 32'hDEADBEEF;

    // Reset held with a pending store
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset weN",      32'(wen2),  32'd1);
    chk("reset oe",       32'(oe2),   32'd0);
    chk("reset readData", rdata2,     32'd0);
    chk("reset ready",    32'(ready2), 32'd0);
    chk("reset sramAddr", 32'(sa2),   32'd0);
    chk("reset dqOut",    32'(dqo2),  32'd0);
    chk("reset ready idle", 32'(ready1), 32'd1);

    // Release reset: store at 1024 proceeds from this cycle
    @(posedge clk); #1;
    rst = 1'b1;
    access(1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 2, 32'd0);

    // Idle cycle after the store
    @(posedge clk); #1;
    wr2 = 1'b0; rd2 = 1'b0;
    @(negedge clk);
    chk("idle ready", 32'(ready2), 32'd1);
    chk("idle readData after write", rdata2, 32'd0);

    // Read back, then back-to-back traffic with no idle gap
    @(posedge clk); #1;
    access(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 2, 32'hDEADBEEF);
    @(posedge clk); #1;
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 2, 32'hDEADBEEF);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 1'b0, 32'd1028, 32'd0, 2, 32'hCAFEF00D);
    @(posedge clk); #1;
    access(1'b0, 1'b0, 1'b1, 32'd1032, 32'h0BADC0DE, 2, 32'hCAFEF00D);

    // Simultaneous read and write: performs the write, readData untouched
    @(posedge clk); #1;
    access(1'b0, 1'b1, 1'b1, 32'd1036, 32'h11223344, 2, 32'hCAFEF00D);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 1'b0, 32'd1036, 32'd0, 2, 32'h11223344);

    // Reset during the high half of a store
    @(posedge clk); #1;
    rd2 = 1'b0; wr2 = 1'b1; addr2 = 32'd1040; wd2 = 32'hAAAA5555;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst pre weN",      32'(wen2), 32'd0);
    chk("midrst pre sramAddr", 32'(sa2),  32'd9);
    rst = 1'b0;
    #1;
    chk("midrst weN",      32'(wen2),  32'd1);
    chk("midrst oe",       32'(oe2),   32'd0);
    chk("midrst readData", rdata2,     32'd0);
    chk("midrst sramAddr", 32'(sa2),   32'd0);
    wr2 = 1'b0;
    #1;
    chk("midrst idle ready", 32'(ready2), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single wait cycle: address map and short access
    @(posedge clk); #1;
    access(1'b1, 1'b0, 1'b1, 32'd1036, 32'h01020304, 1, 32'd0);
    @(posedge clk); #1;
    access(1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 1, 32'h01020304);
    @(posedge clk); #1;
    rd1 = 1'b0; wr1 = 1'b0;
    @(negedge clk);
    chk("W1 idle ready", 32'(ready1), 32'd1);
    chk("W1 readData hold", rdata1, 32'h01020304);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
